d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 28 ++
 tb/tb_d_flip_flop.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// Parameterised D-type register with asynchronous active-low reset.
// q is taken straight from the storage element; there is no path from d to q.
module d_flip_flop #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: default 1-bit build and an 8-bit build resetting to 8'hA5.
// Vector table, hand-written async/glitch sequences, then random cycles against a reference model.
module tb_d_flip_flop;

  localparam logic [7:0] W_RST = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, d, q;
  logic       rst_w;
  logic [7:0] d_w, q_w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  d_flip_flop u_dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  d_flip_flop #(
    .WIDTH   (8),
    .RST_VAL (W_RST)
  ) u_dut_w (
    .clk (clk),
    .rst (rst_w),
    .d   (d_w),
    .q   (q_w)
  );

  typedef struct {
    logic rst;
    logic d;
    logic exp_q;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: q=%h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic       m_q, n_q, r_rst, r_d;
    logic [7:0] m_w, n_w, r_dw;

    rst = 1'b1; d = 1'b0; rst_w = 1'b1; d_w = 8'h00;
    #2;
    rst = 1'b0; rst_w = 1'b0;
    #1;
    check("reset_q", {7'd0, q}, 8'h00);
    check("reset_q_w", q_w, W_RST);

    // Inputs change on falling edges; q is expected one rising edge later.
    tbl[0] = '{rst: 1'b0, d: 1'b1, exp_q: 1'b0};
    tbl[1] = '{rst: 1'b0, d: 1'b1, exp_q: 1'b0};
    tbl[2] = '{rst: 1'b0, d: 1'b1, exp_q: 1'b0};
    tbl[3] = '{rst: 1'b1, d: 1'b0, exp_q: 1'b0};
    tbl[4] = '{rst: 1'b1, d: 1'b1, exp_q: 1'b1};
    tbl[5] = '{rst: 1'b1, d: 1'b1, exp_q: 1'b1};
    tbl[6] = '{rst: 1'b1, d: 1'b0, exp_q: 1'b0};
    tbl[7] = '{rst: 1'b1, d: 1'b1, exp_q: 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      d   = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("table_%0d", i), {7'd0, q}, {7'd0, tbl[i].exp_q});
    end

    // Asynchronous assertion mid-period, then reset dominating an edge with d=1.
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_assert", {7'd0, q}, 8'h00);
    @(posedge clk);
    #1 check("reset_dominates", {7'd0, q}, 8'h00);

    // Release mid-period: q holds reset value until the next edge captures d.
    #2 d = 1'b1; rst = 1'b1;
    #1 check("release_hold", {7'd0, q}, 8'h00);
    @(posedge clk);
    #1 check("release_capture", {7'd0, q}, 8'h01);

    // Capture 0, then glitch d between edges.
    d = 1'b0;
    @(posedge clk);
    #1 check("capture_0", {7'd0, q}, 8'h00);
    #1 d = 1'b1;
    #2 check("glitch_hold", {7'd0, q}, 8'h00);
    d = 1'b0;
    @(posedge clk);
    #1 check("glitch_after_edge", {7'd0, q}, 8'h00);

    // Short reset pulse while q=1.
    d = 1'b1;
    @(posedge clk);
    #1 check("pulse_pre", {7'd0, q}, 8'h01);
    #2 rst = 1'b0;
    #1 check("pulse_assert", {7'd0, q}, 8'h00);
    #2 rst = 1'b1;
    #1 check("pulse_release", {7'd0, q}, 8'h00);
    @(posedge clk);
    #1 check("pulse_reload", {7'd0, q}, 8'h01);

    // Wide build: release and capture, then async reset back to A5.
    @(negedge clk);
    rst_w = 1'b1; d_w = 8'h3C;
    #1 check("wide_release_hold", q_w, W_RST);
    @(posedge clk);
    #1 check("wide_capture", q_w, 8'h3C);
    #2 rst_w = 1'b0;
    #1 check("wide_async_reset", q_w, W_RST);

    // Random cycles. Reference: q is RST_VAL while rst is low, otherwise the d seen at the last edge.
    m_q = 1'b0;
    m_w = W_RST;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r_rst = (i == 0) ? 1'b0 : ($urandom_range(7) != 0);
      r_d   = 1'($urandom);
      r_dw  = 8'($urandom);
      rst   = r_rst; d   = r_d;
      rst_w = r_rst; d_w = r_dw;
      #1;
      check("rand_mid", {7'd0, q}, {7'd0, (r_rst ? m_q : 1'b0)});
      check("rand_mid_w", q_w, r_rst ? m_w : W_RST);
      n_q = r_rst ? r_d  : 1'b0;
      n_w = r_rst ? r_dw : W_RST;
      @(posedge clk);
      #1;
      check("rand_edge", {7'd0, q}, {7'd0, n_q});
      check("rand_edge_w", q_w, n_w);
      m_q = n_q;
      m_w = n_w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
